// File: rtl/credit_bank.sv
// Slot machine credit register with coin/win/bet arithmetic and an
// iterative double-dabble BCD converter feeding the display digits.
module credit_bank #(
  parameter int BET        = 10,
  parameter int MAX_CREDIT = 9999
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        b1,
  input  logic        b10,
  input  logic        b50,
  input  logic        b100,
  input  logic        spin_req,
  input  logic        win_valid,
  input  logic [13:0] win_amt,
  output logic        spin_grant,
  output logic        spin_deny,
  output logic [13:0] credit,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic [3:0]  num4,
  output logic        conv_busy
);

  localparam logic [15:0] MAX16 = 16'(MAX_CREDIT);
  localparam logic [15:0] BET16 = 16'(BET);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } st_e;

  st_e         st_q, st_d;
  logic [3:0]  btn, prev_q, rise;
  logic [15:0] add, sum, tmp, res;
  logic [13:0] credit_q, credit_d;
  logic        grant_q, grant_d;
  logic        deny_q, deny_d;
  logic        changed;
  logic        dirty_q, dirty_d;
  logic [15:0] bcd_q, bcd_adj, bcd_sh;
  logic [13:0] bin_q, bin_sh;
  logic [3:0]  cnt_q;
  logic [15:0] dig_q;

  assign btn  = {b100, b50, b10, b1};
  assign rise = btn & ~prev_q;

  always_comb begin
    add = {2'b00, win_amt & {14{win_valid}}};
    if (rise[0]) add = add + 16'd1;
    if (rise[1]) add = add + 16'd10;
    if (rise[2]) add = add + 16'd50;
    if (rise[3]) add = add + 16'd100;
    sum = {2'b00, credit_q} + add;
    tmp = (sum > MAX16) ? MAX16 : sum;
  end

  always_comb begin
    res     = tmp;
    grant_d = 1'b0;
    deny_d  = 1'b0;
    unique case (1'b1)
      spin_req && (tmp >= BET16): begin
        res     = tmp - BET16;
        grant_d = 1'b1;
      end
      spin_req && (tmp < BET16): deny_d = 1'b1;
      default: ;
    endcase
    credit_d = res[13:0];
    changed  = credit_d != credit_q;
  end

  // A change on the same edge as the snapshot keeps dirty set
  always_comb begin
    dirty_d = dirty_q | changed;
    if (st_q == IDLE && dirty_q) dirty_d = changed;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      prev_q   <= 4'hF;
      credit_q <= '0;
      grant_q  <= 1'b0;
      deny_q   <= 1'b0;
      dirty_q  <= 1'b0;
    end else begin
      prev_q   <= btn;
      credit_q <= credit_d;
      grant_q  <= grant_d;
      deny_q   <= deny_d;
      dirty_q  <= dirty_d;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[14:0], bin_q[13]};
    bin_sh = {bin_q[12:0], 1'b0};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) st_q <= IDLE;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:  if (dirty_q) st_d = LOAD;
      LOAD:  st_d = SHIFT;
      SHIFT: if (cnt_q == 4'd1) st_d = DONE;
      DONE:  st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Snapshot is taken on the edge entering LOAD; shifts run out of LOAD/SHIFT
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
      dig_q <= '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (dirty_q) begin
            bcd_q <= '0;
            bin_q <= credit_q;
            cnt_q <= 4'd14;
          end
        end
        LOAD, SHIFT: begin
          bcd_q <= bcd_sh;
          bin_q <= bin_sh;
          cnt_q <= cnt_q - 4'd1;
        end
        DONE: dig_q <= bcd_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    conv_busy = st_q != IDLE;
  end

  assign spin_grant = grant_q;
  assign spin_deny  = deny_q;
  assign credit     = credit_q;
  assign num1       = dig_q[15:12];
  assign num2       = dig_q[11:8];
  assign num3       = dig_q[7:4];
  assign num4       = dig_q[3:0];

endmodule

// File: tb/tb_credit_bank.sv
// Bench for credit_bank: directed scenarios plus random traffic
// checked against an arithmetic model of the balance and display.
module tb_credit_bank;

  logic        clk = 1'b0;
  logic        clr;
  logic        b1, b10, b50, b100;
  logic        spin_req, win_valid;
  logic [13:0] win_amt;
  logic        spin_grant, spin_deny, conv_busy;
  logic [13:0] credit;
  logic [3:0]  num1, num2, num3, num4;

  int n_cmp = 0;
  int n_err = 0;

  int       m_credit;
  bit       m_grant, m_deny;
  bit [3:0] m_prev;
  bit       seen[int];

  credit_bank dut (
    .clk(clk), .clr(clr),
    .b1(b1), .b10(b10), .b50(b50), .b100(b100),
    .spin_req(spin_req), .win_valid(win_valid), .win_amt(win_amt),
    .spin_grant(spin_grant), .spin_deny(spin_deny),
    .credit(credit),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int disp();
    return num1 * 1000 + num2 * 100 + num3 * 10 + num4;
  endfunction

  function automatic bit digits_ok();
    return num1 < 10 && num2 < 10 && num3 < 10 && num4 < 10;
  endfunction

  task automatic tick();
    int add;
    int tmp;
    bit [3:0] c;
    c   = {b100, b50, b10, b1};
    add = 0;
    if (c[0] && !m_prev[0]) add += 1;
    if (c[1] && !m_prev[1]) add += 10;
    if (c[2] && !m_prev[2]) add += 50;
    if (c[3] && !m_prev[3]) add += 100;
    if (win_valid) add += int'(win_amt);
    m_prev = c;
    tmp = m_credit + add;
    if (tmp > 9999) tmp = 9999;
    m_grant = 0;
    m_deny  = 0;
    if (spin_req) begin
      if (tmp >= 10) begin
        tmp -= 10;
        m_grant = 1;
      end else begin
        m_deny = 1;
      end
    end
    m_credit = tmp;
    @(posedge clk);
    #1;
    chk("credit", int'(credit), m_credit);
    chk("grant", int'(spin_grant), int'(m_grant));
    chk("deny", int'(spin_deny), int'(m_deny));
    seen[m_credit] = 1;
    chk("disp_bcd", int'(digits_ok()), 1);
    chk("disp_hist", int'(seen.exists(disp())), 1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulses_off();
    spin_req  = 1'b0;
    win_valid = 1'b0;
    win_amt   = '0;
  endtask

  task automatic rst();
    clr = 1'b0;
    #1;
    m_credit = 0;
    m_grant  = 0;
    m_deny   = 0;
    m_prev   = 4'hF;
    seen.delete();
    seen[0] = 1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_disp", disp(), 0);
    chk("rst_busy", int'(conv_busy), 0);
    chk("rst_grant", int'(spin_grant), 0);
    chk("rst_deny", int'(spin_deny), 0);
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic press(input int which);
    case (which)
      0: b1 = 1'b1;
      1: b10 = 1'b1;
      2: b50 = 1'b1;
      default: b100 = 1'b1;
    endcase
    tick();
    {b100, b50, b10, b1} = 4'b0;
    tick();
  endtask

  int busy_n, first;

  initial begin
    clr = 1'b0;
    {b100, b50, b10, b1} = 4'b0;
    pulses_off();

    // b10 held: one credit, latency and busy width
    rst();
    tick();
    b10 = 1'b1;
    tick();
    busy_n = 0;
    first  = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (conv_busy) busy_n++;
      if (first == 0 && disp() == 10) first = i;
    end
    chk("held_credit", int'(credit), 10);
    chk("busy_len", busy_n, 15);
    chk("dig_lat", first, 16);
    b10 = 1'b0;

    // all four coins on one edge
    rst();
    tick();
    {b100, b50, b10, b1} = 4'hF;
    tick();
    chk("sum161", int'(credit), 161);
    ticks(18);
    chk("d161_1", int'(num1), 0);
    chk("d161_2", int'(num2), 1);
    chk("d161_3", int'(num3), 6);
    chk("d161_4", int'(num4), 1);
    {b100, b50, b10, b1} = 4'b0;

    // deny at 5, then grant with a coin on the same edge
    rst();
    tick();
    for (int i = 0; i < 5; i++) press(0);
    spin_req = 1'b1;
    tick();
    chk("deny_pulse", int'(spin_deny), 1);
    chk("deny_credit", int'(credit), 5);
    b10 = 1'b1;
    tick();
    chk("grant_pulse", int'(spin_grant), 1);
    chk("grant_credit", int'(credit), 5);
    pulses_off();
    b10 = 1'b0;
    tick();
    chk("grant_clear", int'(spin_grant), 0);

    // saturation at the ceiling
    rst();
    tick();
    win_valid = 1'b1;
    win_amt   = 14'd9990;
    tick();
    win_amt = 14'd100;
    tick();
    pulses_off();
    chk("sat", int'(credit), 9999);
    ticks(34);
    chk("d9999", disp(), 9999);

    // two edges during one conversion
    rst();
    tick();
    b1 = 1'b1;
    tick();
    ticks(2);
    b1 = 1'b0;
    tick();
    b1 = 1'b1;
    tick();
    ticks(32);
    chk("restale", disp(), 2);
    b1 = 1'b0;

    // clear mid-shift with b50 held through release
    rst();
    tick();
    b100 = 1'b1;
    tick();
    ticks(5);
    chk("mid_busy", int'(conv_busy), 1);
    b50 = 1'b1;
    #2;
    rst();
    ticks(20);
    chk("held50", int'(credit), 0);
    chk("held50_d", disp(), 0);
    {b100, b50, b10, b1} = 4'b0;

    // random traffic
    rst();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) b1 = ~b1;
      if ($urandom_range(0, 5) == 0) b10 = ~b10;
      if ($urandom_range(0, 7) == 0) b50 = ~b50;
      if ($urandom_range(0, 7) == 0) b100 = ~b100;
      spin_req  = ($urandom_range(0, 4) == 0);
      win_valid = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 49) == 0) win_amt = 14'($urandom_range(0, 16383));
      else                            win_amt = 14'($urandom_range(0, 200));
      tick();
    end
    pulses_off();
    ticks(40);
    chk("rand_final", disp(), m_credit);
    chk("rand_idle", int'(conv_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
